// File: rtl/sprite_sched.sv
// sprite_sched: per-frame sprite position scheduler and pixel compositor.
//
// Holds the working position and velocity of NSPR sprites. On each frame
// pulse it walks the sprites one at a time: MOVE adds the velocity, CHECK
// clamps the result to the screen and reflects the velocity. COMMIT then
// copies every working position to the published outputs in a single cycle,
// so the sprite instances never see a half-updated set. A compositor runs
// every cycle: it picks the lowest-index opaque sprite and gathers overlap
// flags, which are published once per frame.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   frame               one-cycle pulse at the start of vertical blanking
//   cfg_we/idx/sel/data working-register write (sel 0=x 1=y 2=dx 3=dy);
//                       only accepted while idle
//   sprx, spry          published positions, sprite i at [i*CORDW +: CORDW]
//   spr_pix/spr_drawing per-sprite pixel index and drawing flag
//   pix, drawing        registered composite pixel and opacity
//   collide             per-sprite overlap flags for the previous frame
//   busy                update sequence in progress

// Single sprite lane: decides whether this sprite covers the current pixel.
module sprite_lane #(
  parameter int DATAW = 4,
  parameter int TRANS = 0
) (
  input  logic [DATAW-1:0] pix,
  input  logic             drawing,
  output logic             opaque
);
  assign opaque = drawing && (pix != DATAW'(TRANS));
endmodule

module sprite_sched #(
  parameter int CORDW = 16,
  parameter int NSPR  = 4,
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int SPR_W = 8,
  parameter int SPR_H = 8,
  parameter int DATAW = 4,
  parameter int TRANS = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame,
  input  logic                     cfg_we,
  input  logic [$clog2(NSPR)-1:0]  cfg_idx,
  input  logic [1:0]               cfg_sel,
  input  logic [CORDW-1:0]         cfg_data,
  output logic [NSPR*CORDW-1:0]    sprx,
  output logic [NSPR*CORDW-1:0]    spry,
  input  logic [NSPR*DATAW-1:0]    spr_pix,
  input  logic [NSPR-1:0]          spr_drawing,
  output logic [DATAW-1:0]         pix,
  output logic                     drawing,
  output logic [NSPR-1:0]          collide,
  output logic                     busy
);
  localparam int IW = $clog2(NSPR);
  localparam logic signed [CORDW-1:0] XMAX = CORDW'(H_RES - SPR_W);
  localparam logic signed [CORDW-1:0] YMAX = CORDW'(V_RES - SPR_H);

  typedef enum logic [1:0] {IDLE, MOVE, CHECK, COMMIT} state_t;

  typedef struct packed {
    logic                    we;
    logic [IW-1:0]           idx;
    logic [1:0]              sel;
    logic [CORDW-1:0]        data;
  } cfg_req_t;

  cfg_req_t cfg;
  assign cfg = '{we: cfg_we, idx: cfg_idx, sel: cfg_sel, data: cfg_data};

  state_t                       state;
  logic [IW-1:0]                idx;
  logic [NSPR-1:0][CORDW-1:0]   wx, wy, wdx, wdy;
  logic [NSPR-1:0][CORDW-1:0]   pub_x, pub_y;
  logic signed [CORDW-1:0]      nx, ny;

  assign sprx = pub_x;
  assign spry = pub_y;

  // Update sequencer. Working registers are only writable while idle, which
  // keeps configuration from racing the per-sprite read-modify-write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      idx   <= '0;
      wx    <= '0;
      wy    <= '0;
      wdx   <= '0;
      wdy   <= '0;
      pub_x <= '0;
      pub_y <= '0;
      nx    <= '0;
      ny    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg.we && (int'(cfg.idx) < NSPR)) begin
            case (cfg.sel)
              2'd0: wx[cfg.idx]  <= cfg.data;
              2'd1: wy[cfg.idx]  <= cfg.data;
              2'd2: wdx[cfg.idx] <= cfg.data;
              default: wdy[cfg.idx] <= cfg.data;
            endcase
          end
          if (frame) begin
            idx   <= '0;
            state <= MOVE;
            busy  <= 1'b1;
          end
        end
        MOVE: begin
          // Wraps on overflow; bounds are applied in CHECK.
          nx    <= wx[idx] + wdx[idx];
          ny    <= wy[idx] + wdy[idx];
          state <= CHECK;
        end
        CHECK: begin
          if (nx < 0) begin
            wx[idx]  <= '0;
            wdx[idx] <= -wdx[idx];
          end else if (nx > XMAX) begin
            wx[idx]  <= XMAX;
            wdx[idx] <= -wdx[idx];
          end else begin
            wx[idx]  <= nx;
          end
          if (ny < 0) begin
            wy[idx]  <= '0;
            wdy[idx] <= -wdy[idx];
          end else if (ny > YMAX) begin
            wy[idx]  <= YMAX;
            wdy[idx] <= -wdy[idx];
          end else begin
            wy[idx]  <= ny;
          end
          if (idx == IW'(NSPR - 1)) state <= COMMIT;
          else begin
            idx   <= idx + 1'b1;
            state <= MOVE;
          end
        end
        COMMIT: begin
          pub_x <= wx;
          pub_y <= wy;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Compositor lanes.
  logic [NSPR-1:0][DATAW-1:0] lane_pix;
  logic [NSPR-1:0]            opq;
  assign lane_pix = spr_pix;

  sprite_lane #(.DATAW(DATAW), .TRANS(TRANS)) u_lane [NSPR-1:0] (
    .pix     (lane_pix),
    .drawing (spr_drawing),
    .opaque  (opq)
  );

  logic [DATAW-1:0] pix_n;
  logic [NSPR-1:0]  hit;
  logic             multi;

  // Walk high to low so the lowest-index opaque sprite wins.
  always_comb begin
    pix_n = DATAW'(TRANS);
    for (int k = NSPR - 1; k >= 0; k--) begin
      if (opq[k]) pix_n = lane_pix[k];
    end
  end

  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi = |(opq & (opq - 1'b1));
  assign hit   = multi ? opq : '0;

  logic [NSPR-1:0] acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix     <= '0;
      drawing <= 1'b0;
      acc     <= '0;
      collide <= '0;
    end else begin
      pix     <= pix_n;
      drawing <= |opq;
      if (state == COMMIT) begin
        collide <= acc;
        acc     <= hit;  // hits in the commit cycle belong to the new frame
      end else begin
        acc     <= acc | hit;
      end
    end
  end
endmodule

// File: tb/tb_sprite_sched.sv
module tb_sprite_sched;
  localparam int CORDW = 16;
  localparam int NSPR  = 4;
  localparam int DATAW = 4;
  localparam int XMAX  = 640 - 8;
  localparam int YMAX  = 480 - 8;

  logic                    clk = 1'b0;
  logic                    rst = 1'b0;
  logic                    frame = 1'b0;
  logic                    cfg_we = 1'b0;
  logic [1:0]              cfg_idx = '0;
  logic [1:0]              cfg_sel = '0;
  logic [CORDW-1:0]        cfg_data = '0;
  logic [NSPR*CORDW-1:0]   sprx, spry;
  logic [NSPR*DATAW-1:0]   spr_pix = '0;
  logic [NSPR-1:0]         spr_drawing = '0;
  logic [DATAW-1:0]        pix;
  logic                    drawing;
  logic [NSPR-1:0]         collide;
  logic                    busy;

  sprite_sched dut (
    .clk(clk), .rst(rst), .frame(frame), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .sprx(sprx), .spry(spry),
    .spr_pix(spr_pix), .spr_drawing(spr_drawing), .pix(pix), .drawing(drawing),
    .collide(collide), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state.
  int mx[NSPR], my[NSPR], mdx[NSPR], mdy[NSPR];
  logic [NSPR-1:0] acc_model = '0;

  typedef struct packed {
    logic [DATAW-1:0] p;
    logic             d;
  } comp_t;

  logic [2*NSPR*CORDW-1:0] pos_q[$];
  logic [NSPR-1:0]         col_q[$];
  comp_t                   comp_q[$];

  function automatic void bounce(inout int p, inout int v, input int lim);
    int n;
    n = p + v;
    if (n < 0) begin p = 0; v = -v; end
    else if (n > lim) begin p = lim; v = -v; end
    else p = n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NSPR; i++) begin
      mx[i] = 0; my[i] = 0; mdx[i] = 0; mdy[i] = 0;
    end
    acc_model = '0;
  endtask

  // Advance the model one frame and queue the expected published state.
  task automatic model_frame();
    logic [NSPR*CORDW-1:0] ex, ey;
    for (int i = 0; i < NSPR; i++) begin
      bounce(mx[i], mdx[i], XMAX);
      bounce(my[i], mdy[i], YMAX);
      ex[i*CORDW +: CORDW] = CORDW'(mx[i]);
      ey[i*CORDW +: CORDW] = CORDW'(my[i]);
    end
    pos_q.push_back({ex, ey});
    col_q.push_back(acc_model);
    acc_model = '0;
  endtask

  task automatic cfg_write(input int i, input int sel, input int val);
    @(negedge clk);
    cfg_we = 1'b1; cfg_idx = 2'(i); cfg_sel = 2'(sel); cfg_data = CORDW'(val);
    @(negedge clk);
    cfg_we = 1'b0;
    case (sel)
      0: mx[i] = val;
      1: my[i] = val;
      2: mdx[i] = val;
      default: mdy[i] = val;
    endcase
  endtask

  // Drive one cycle of sprite pixels and queue the expected composite.
  task automatic drive_pix(input logic [NSPR-1:0] drw, input logic [NSPR*DATAW-1:0] p);
    comp_t e;
    logic [NSPR-1:0] o;
    int cnt;
    @(negedge clk);
    spr_drawing = drw; spr_pix = p;
    e.p = '0; e.d = 1'b0; cnt = 0; o = '0;
    for (int k = 0; k < NSPR; k++) begin
      if (drw[k] && p[k*DATAW +: DATAW] != '0) begin
        o[k] = 1'b1; cnt++;
        if (!e.d) begin e.p = p[k*DATAW +: DATAW]; e.d = 1'b1; end
      end
    end
    if (cnt >= 2) acc_model |= o;
    comp_q.push_back(e);
  endtask

  task automatic frame_and_wait(output int n);
    model_frame();
    @(negedge clk) frame = 1'b1;
    @(negedge clk) frame = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    logic [2*NSPR*CORDW-1:0] ep;
    logic [NSPR-1:0] ec;
    comp_t e;
    #1 rst = 1'b1;
    #2;
    total++;
    if ({sprx, spry, pix, drawing, collide, busy} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h req=0", {sprx, spry, pix, drawing, collide, busy});
    end
    @(negedge clk); @(negedge clk) rst = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b req=0", busy); end
    end
    // Give the outputs something nonzero to lose.
    cfg_write(0, 0, 20);
    drive_pix(4'b1001, {4'h2, 4'h0, 4'h0, 4'h3});
    drive_pix(4'b0000, '0);
    e = comp_q.pop_front();
    total++;
    if ({pix, drawing} !== {e.p, e.d}) begin bad++; $display("FAIL reset_pre_pix got=%h/%b req=%h/%b", pix, drawing, e.p, e.d); end
    @(negedge clk);
    e = comp_q.pop_front();
    total++;
    if ({pix, drawing} !== {e.p, e.d}) begin bad++; $display("FAIL reset_pre_clear got=%h/%b req=%h/%b", pix, drawing, e.p, e.d); end
    frame_and_wait(n);
    ep = pos_q.pop_front(); ec = col_q.pop_front();
    total++;
    if (n != 9) begin bad++; $display("FAIL reset_pre_busy got=%0d req=9", n); end
    total++;
    if ({sprx, spry} !== ep || collide !== ec || collide !== 4'b1001) begin
      bad++; $display("FAIL reset_pre_frame got=%h/%b req=%h/%b", {sprx, spry}, collide, ep, ec);
    end
    // Start another update and abort it partway.
    @(negedge clk) begin spr_drawing = 4'b0010; spr_pix = {4'h0, 4'h0, 4'h6, 4'h0}; frame = 1'b1; end
    @(negedge clk) frame = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || pix !== 4'h6) begin bad++; $display("FAIL reset_mid_pre got=%b/%h req=1/6", busy, pix); end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({sprx, spry, pix, drawing, collide, busy} !== '0) begin
      bad++; $display("FAIL reset_async got=%h req=0", {sprx, spry, pix, drawing, collide, busy});
    end
    spr_drawing = '0; spr_pix = '0;
    @(negedge clk) rst = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_after_busy got=%b req=0", busy); end
    end
  endtask

  task automatic test_move();
    int n;
    logic [2*NSPR*CORDW-1:0] ep;
    logic [NSPR-1:0] ec;
    cfg_write(0, 0, 100);
    cfg_write(0, 1, 50);
    cfg_write(0, 2, 3);
    cfg_write(0, 3, -2);
    total++;
    if (sprx !== '0 || spry !== '0) begin bad++; $display("FAIL move_pre_commit got=%h/%h req=0", sprx, spry); end
    model_frame();
    @(negedge clk) frame = 1'b1;
    @(negedge clk) frame = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      total++;
      if (sprx[CORDW-1:0] !== '0) begin bad++; $display("FAIL move_hold cyc=%0d got=%0d req=0", n, sprx[CORDW-1:0]); end
      @(negedge clk);
    end
    ep = pos_q.pop_front(); ec = col_q.pop_front();
    total++;
    if (n != 9) begin bad++; $display("FAIL move_busy_len got=%0d req=9", n); end
    total++;
    if ({sprx, spry} !== ep) begin bad++; $display("FAIL move_pos got=%h req=%h", {sprx, spry}, ep); end
    total++;
    if (sprx[CORDW-1:0] !== 16'd103 || spry[CORDW-1:0] !== 16'd48) begin
      bad++; $display("FAIL move_s0 got=%0d,%0d req=103,48", sprx[CORDW-1:0], spry[CORDW-1:0]);
    end
    total++;
    if (sprx[NSPR*CORDW-1:CORDW] !== '0 || spry[NSPR*CORDW-1:CORDW] !== '0) begin
      bad++; $display("FAIL move_others got=%h/%h req=0", sprx[NSPR*CORDW-1:CORDW], spry[NSPR*CORDW-1:CORDW]);
    end
    total++;
    if (collide !== ec) begin bad++; $display("FAIL move_collide got=%b req=%b", collide, ec); end
  endtask

  task automatic test_bounce();
    int n;
    logic [2*NSPR*CORDW-1:0] ep;
    logic [NSPR-1:0] ec;
    cfg_write(1, 0, 630);
    cfg_write(1, 2, 5);
    cfg_write(1, 1, 1);
    cfg_write(1, 3, -3);
    frame_and_wait(n);
    ep = pos_q.pop_front(); ec = col_q.pop_front();
    total++;
    if ({sprx, spry} !== ep || n != 9) begin bad++; $display("FAIL bounce_f1 got=%h n=%0d req=%h n=9", {sprx, spry}, n, ep); end
    total++;
    if (sprx[CORDW +: CORDW] !== 16'd632 || spry[CORDW +: CORDW] !== 16'd0) begin
      bad++; $display("FAIL bounce_clamp got=%0d,%0d req=632,0", sprx[CORDW +: CORDW], spry[CORDW +: CORDW]);
    end
    frame_and_wait(n);
    ep = pos_q.pop_front(); ec = col_q.pop_front();
    total++;
    if ({sprx, spry} !== ep) begin bad++; $display("FAIL bounce_f2 got=%h req=%h", {sprx, spry}, ep); end
    total++;
    if (sprx[CORDW +: CORDW] !== 16'd627 || spry[CORDW +: CORDW] !== 16'd3) begin
      bad++; $display("FAIL bounce_reflect got=%0d,%0d req=627,3", sprx[CORDW +: CORDW], spry[CORDW +: CORDW]);
    end
    cfg_write(1, 0, 632);
    cfg_write(1, 2, 0);
    frame_and_wait(n);
    ep = pos_q.pop_front(); ec = col_q.pop_front();
    total++;
    if ({sprx, spry} !== ep || sprx[CORDW +: CORDW] !== 16'd632) begin
      bad++; $display("FAIL bounce_edge got=%0d req=632 full=%h exp=%h", sprx[CORDW +: CORDW], {sprx, spry}, ep);
    end
    total++;
    if (collide !== ec) begin bad++; $display("FAIL bounce_collide got=%b req=%b", collide, ec); end
  endtask

  task automatic test_priority();
    comp_t e;
    drive_pix(4'b0110, {4'h0, 4'h7, 4'h5, 4'h0});
    drive_pix(4'b0110, {4'h0, 4'h7, 4'h0, 4'h0});
    e = comp_q.pop_front();
    total++;
    if ({pix, drawing} !== {e.p, e.d} || pix !== 4'h5) begin bad++; $display("FAIL prio_low_wins got=%h/%b req=%h/%b", pix, drawing, e.p, e.d); end
    drive_pix(4'b0000, {4'hf, 4'hf, 4'hf, 4'hf});
    e = comp_q.pop_front();
    total++;
    if ({pix, drawing} !== {e.p, e.d} || pix !== 4'h7) begin bad++; $display("FAIL prio_transparent got=%h/%b req=%h/%b", pix, drawing, e.p, e.d); end
    drive_pix(4'b1000, {4'h9, 4'h0, 4'h0, 4'h0});
    e = comp_q.pop_front();
    total++;
    if ({pix, drawing} !== {e.p, e.d} || drawing !== 1'b0) begin bad++; $display("FAIL prio_none got=%h/%b req=%h/%b", pix, drawing, e.p, e.d); end
    drive_pix(4'b0000, '0);
    e = comp_q.pop_front();
    total++;
    if ({pix, drawing} !== {e.p, e.d}) begin bad++; $display("FAIL prio_single got=%h/%b req=%h/%b", pix, drawing, e.p, e.d); end
    @(negedge clk);
    e = comp_q.pop_front();
    total++;
    if ({pix, drawing} !== {e.p, e.d}) begin bad++; $display("FAIL prio_idle got=%h/%b req=%h/%b", pix, drawing, e.p, e.d); end
  endtask

  task automatic test_collision();
    int n;
    logic [2*NSPR*CORDW-1:0] ep;
    logic [NSPR-1:0] ec;
    frame_and_wait(n);
    ep = pos_q.pop_front(); ec = col_q.pop_front();
    total++;
    if (collide !== ec || collide !== 4'b0110) begin bad++; $display("FAIL collide_set got=%b req=%b", collide, ec); end
    total++;
    if ({sprx, spry} !== ep) begin bad++; $display("FAIL collide_pos got=%h req=%h", {sprx, spry}, ep); end
    frame_and_wait(n);
    ep = pos_q.pop_front(); ec = col_q.pop_front();
    total++;
    if (collide !== ec || collide !== 4'b0000) begin bad++; $display("FAIL collide_clear got=%b req=%b", collide, ec); end
  endtask

  task automatic test_dropped();
    int n;
    logic [2*NSPR*CORDW-1:0] ep;
    logic [NSPR-1:0] ec;
    model_frame();
    @(negedge clk) frame = 1'b1;
    @(negedge clk) frame = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      if (n == 2) begin cfg_we = 1'b1; cfg_idx = 2'd0; cfg_sel = 2'd0; cfg_data = 16'd500; end
      if (n == 3) cfg_we = 1'b0;
      if (n == 4) frame = 1'b1;
      if (n == 5) frame = 1'b0;
      @(negedge clk);
    end
    cfg_we = 1'b0; frame = 1'b0;
    ep = pos_q.pop_front(); ec = col_q.pop_front();
    total++;
    if (n != 9) begin bad++; $display("FAIL drop_busy_len got=%0d req=9", n); end
    total++;
    if ({sprx, spry} !== ep) begin bad++; $display("FAIL drop_cfg got=%h req=%h", {sprx, spry}, ep); end
    total++;
    if (collide !== ec) begin bad++; $display("FAIL drop_collide got=%b req=%b", collide, ec); end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || {sprx, spry} !== ep) begin
        bad++; $display("FAIL drop_no_extra cyc=%0d busy=%b pos=%h req=0/%h", c, busy, {sprx, spry}, ep);
      end
    end
  endtask

  initial begin
    test_reset();
    test_move();
    test_bounce();
    test_priority();
    test_collision();
    test_dropped();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
